// File: rtl/ctrl_seq_pkg.sv
// Shared types for the control sequencer: opcode classes, FSM states and
// the decoded control bundle passed from the decoder to the output register.
package ctrl_seq_pkg;

   localparam int unsigned CLS_W = 3;
   // Address fields are carried at a fixed width; modules use the low RW bits.
   localparam int unsigned AW = 8;

   typedef enum logic [CLS_W-1:0] {
      kSHIFT = 3'b000,
      kACC   = 3'b001,
      kST    = 3'b010,
      kLD    = 3'b011,
      kJ     = 3'b100,
      kCMP   = 3'b101,
      kBRE   = 3'b110,
      kHALT  = 3'b111
   } op_class_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      LOAD_WAIT = 2'd2,
      HALT      = 2'd3
   } state_e;

   typedef struct packed {
      op_class_e       op_class;
      logic [AW-1:0]   raddr_a;
      logic [AW-1:0]   raddr_b;
      logic [AW-1:0]   waddr;
      logic            write_en;
      logic            read_mem;
      logic            write_mem;
      logic            jump_en;
      logic            branch_en;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: maps one instruction word to a control
// bundle; branch resolution uses the eq_c value supplied by the sequencer.
module ctrl_decode
   import ctrl_seq_pkg::*;
#(
   parameter int unsigned IW      = 9,
   parameter int unsigned RW      = 3,
   parameter int unsigned ACC_REG = 0
) (
   input  logic [IW-1:0] inst,
   input  logic          eq_c,
   output ctrl_t         ctrl_c
);

   op_class_e     cls_c;
   logic [AW-1:0] ra_c;
   logic [AW-1:0] rb_c;
   logic [AW-1:0] acc_c;

   assign cls_c = op_class_e'(inst[IW-1 -: CLS_W]);
   assign ra_c  = AW'(inst[2*RW-1:RW]);
   assign rb_c  = AW'(inst[RW-1:0]);
   assign acc_c = AW'(ACC_REG);

   always_comb begin
      ctrl_c          = CTRL_NONE;
      ctrl_c.op_class = cls_c;
      case (cls_c)
         kSHIFT: begin
            ctrl_c.raddr_a  = ra_c;
            ctrl_c.raddr_b  = rb_c;
            ctrl_c.waddr    = ra_c;
            ctrl_c.write_en = 1'b1;
         end
         kACC: begin
            ctrl_c.raddr_a  = acc_c;
            ctrl_c.raddr_b  = rb_c;
            ctrl_c.waddr    = acc_c;
            ctrl_c.write_en = 1'b1;
         end
         kST: begin
            ctrl_c.raddr_a   = ra_c;
            ctrl_c.raddr_b   = rb_c;
            ctrl_c.write_mem = 1'b1;
         end
         kLD: begin
            ctrl_c.raddr_b  = rb_c;
            ctrl_c.waddr    = ra_c;
            ctrl_c.read_mem = 1'b1;
         end
         kJ: begin
            ctrl_c.raddr_b = rb_c;
            ctrl_c.jump_en = 1'b1;
         end
         kCMP: begin
            ctrl_c.raddr_a = ra_c;
            ctrl_c.raddr_b = rb_c;
         end
         kBRE: begin
            ctrl_c.raddr_b   = rb_c;
            ctrl_c.branch_en = eq_c;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_seq.sv
// Registered control sequencer: run/halt FSM, multi-cycle load with PC stall,
// latched compare flag with same-cycle forwarding, registered control outputs.
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int unsigned IW      = 9,
   parameter int unsigned RW      = 3,
   parameter int unsigned ACC_REG = 0,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [IW-1:0] inst,
   input  logic          inst_valid,
   input  logic          ZERO,
   output logic [2:0]    op_class,
   output logic [RW-1:0] rAddrA,
   output logic [RW-1:0] rAddrB,
   output logic [RW-1:0] wAddr,
   output logic          write_en,
   output logic          ReadMem,
   output logic          WriteMem,
   output logic          jump_en,
   output logic          branch_en,
   output logic          stall,
   output logic          done
);

   localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flag_q, flag_d;
   logic             cmp_pend_q, cmp_pend_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             stall_q, stall_d;
   logic             done_q, done_d;

   ctrl_t            dec_c;
   logic             eq_c;
   logic             unused_addr_c;

   // A compare still in its execute cycle forwards the live ALU result.
   assign eq_c = cmp_pend_q ? ZERO : flag_q;

   ctrl_decode #(
      .IW      (IW),
      .RW      (RW),
      .ACC_REG (ACC_REG)
   ) u_decode (
      .inst   (inst),
      .eq_c   (eq_c),
      .ctrl_c (dec_c)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      flag_d     = flag_q;
      cmp_pend_d = 1'b0;
      ctrl_d     = CTRL_NONE;
      stall_d    = 1'b0;
      done_d     = 1'b0;

      if (cmp_pend_q) flag_d = ZERO;

      case (state_q)
         IDLE: begin
            if (Start) state_d = RUN;
         end
         HALT: begin
            if (Start) begin
               state_d = RUN;
               flag_d  = 1'b0;
            end else begin
               done_d = 1'b1;
            end
         end
         RUN, LOAD_WAIT: begin
            if (state_q == LOAD_WAIT && cnt_q != '0) begin
               // Load still in flight: hold its fields, keep reading memory.
               cnt_d           = cnt_q - CNT_W'(1);
               ctrl_d          = ctrl_q;
               ctrl_d.write_en = (cnt_d == '0);
               stall_d         = (cnt_d != '0);
            end else begin
               state_d = RUN;
               if (inst_valid) begin
                  ctrl_d = dec_c;
                  case (dec_c.op_class)
                     kLD: begin
                        state_d         = LOAD_WAIT;
                        cnt_d           = CNT_W'(MEM_LAT - 1);
                        ctrl_d.write_en = (MEM_LAT == 1);
                        stall_d         = (MEM_LAT > 1);
                     end
                     kCMP:  cmp_pend_d = 1'b1;
                     kHALT: begin
                        state_d = HALT;
                        done_d  = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         flag_q     <= 1'b0;
         cmp_pend_q <= 1'b0;
         ctrl_q     <= CTRL_NONE;
         stall_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         flag_q     <= flag_d;
         cmp_pend_q <= cmp_pend_d;
         ctrl_q     <= ctrl_d;
         stall_q    <= stall_d;
         done_q     <= done_d;
      end
   end

   // Upper address bits beyond RW are always zero.
   assign unused_addr_c = ^{ctrl_q.raddr_a, ctrl_q.raddr_b, ctrl_q.waddr};

   assign op_class  = ctrl_q.op_class;
   assign rAddrA    = ctrl_q.raddr_a[RW-1:0];
   assign rAddrB    = ctrl_q.raddr_b[RW-1:0];
   assign wAddr     = ctrl_q.waddr[RW-1:0];
   assign write_en  = ctrl_q.write_en;
   assign ReadMem   = ctrl_q.read_mem;
   assign WriteMem  = ctrl_q.write_mem;
   assign jump_en   = ctrl_q.jump_en;
   assign branch_en = ctrl_q.branch_en;
   assign stall     = stall_q;
   assign done      = done_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed, table-driven bench for ctrl_seq with IW=9, RW=3, ACC_REG=0, MEM_LAT=2.
module tb_ctrl_seq;

   logic       Clk;
   logic       Reset;
   logic       Start;
   logic [8:0] inst;
   logic       inst_valid;
   logic       ZERO;
   logic [2:0] op_class;
   logic [2:0] rAddrA, rAddrB, wAddr;
   logic       write_en, ReadMem, WriteMem, jump_en, branch_en, stall, done;

   int errors = 0;
   int checks = 0;

   ctrl_seq #(.IW(9), .RW(3), .ACC_REG(0), .MEM_LAT(2)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .inst       (inst),
      .inst_valid (inst_valid),
      .ZERO       (ZERO),
      .op_class   (op_class),
      .rAddrA     (rAddrA),
      .rAddrB     (rAddrB),
      .wAddr      (wAddr),
      .write_en   (write_en),
      .ReadMem    (ReadMem),
      .WriteMem   (WriteMem),
      .jump_en    (jump_en),
      .branch_en  (branch_en),
      .stall      (stall),
      .done       (done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Expected output word: {cls, rA, rB, wA, we, rm, wm, j, b, stall, done}
   typedef struct {
      logic        start;
      logic        valid;
      logic [8:0]  in;
      logic        zero;
      logic [18:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [18:0] e(int cls, int ra, int rb, int wa, bit we, bit rm,
                                     bit wm, bit j, bit b, bit st, bit dn);
      return {3'(cls), 3'(ra), 3'(rb), 3'(wa), we, rm, wm, j, b, st, dn};
   endfunction

   function automatic vec_t mk(logic st, logic vl, logic [8:0] in, logic z, logic [18:0] ex);
      vec_t v;
      v.start = st; v.valid = vl; v.in = in; v.zero = z; v.exp = ex;
      return v;
   endfunction

   function automatic logic [18:0] outs();
      return {op_class, rAddrA, rAddrB, wAddr, write_en, ReadMem, WriteMem,
              jump_en, branch_en, stall, done};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic vl, input logic [8:0] in, input logic z);
      Start = st; inst_valid = vl; inst = in; ZERO = z;
   endtask

   localparam logic [18:0] ZEROS = '0;

   initial begin
      vecs.push_back(mk(0, 1, 9'b000_011_101, 0, e(0,3,5,3,1,0,0,0,0,0,0)));
      vecs.push_back(mk(0, 1, 9'b001_010_110, 0, e(1,0,6,0,1,0,0,0,0,0,0)));
      vecs.push_back(mk(0, 1, 9'b011_010_110, 0, e(3,0,6,2,0,1,0,0,0,1,0)));
      vecs.push_back(mk(0, 1, 9'b010_100_001, 0, e(3,0,6,2,1,1,0,0,0,0,0)));
      vecs.push_back(mk(0, 1, 9'b010_100_001, 0, e(2,4,1,0,0,0,1,0,0,0,0)));
      vecs.push_back(mk(0, 0, 9'b000_111_111, 0, e(0,0,0,0,0,0,0,0,0,0,0)));
      vecs.push_back(mk(0, 1, 9'b100_000_111, 0, e(4,0,7,0,0,0,0,1,0,0,0)));
      vecs.push_back(mk(0, 1, 9'b101_001_010, 0, e(5,1,2,0,0,0,0,0,0,0,0)));
      vecs.push_back(mk(0, 1, 9'b110_000_001, 1, e(6,0,1,0,0,0,0,0,1,0,0)));
      vecs.push_back(mk(0, 1, 9'b101_011_011, 0, e(5,3,3,0,0,0,0,0,0,0,0)));
      vecs.push_back(mk(0, 1, 9'b110_000_001, 0, e(6,0,1,0,0,0,0,0,0,0,0)));
      vecs.push_back(mk(0, 1, 9'b101_000_000, 0, e(5,0,0,0,0,0,0,0,0,0,0)));
      vecs.push_back(mk(0, 0, 9'b000_000_000, 1, e(0,0,0,0,0,0,0,0,0,0,0)));
      vecs.push_back(mk(0, 1, 9'b010_001_010, 0, e(2,1,2,0,0,0,1,0,0,0,0)));
      vecs.push_back(mk(0, 1, 9'b110_000_001, 0, e(6,0,1,0,0,0,0,0,1,0,0)));
      vecs.push_back(mk(0, 1, 9'b111_000_000, 0, e(7,0,0,0,0,0,0,0,0,0,1)));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(0, 1, 9'b000_001_001, 0, e(0,0,0,0,0,0,0,0,0,0,1)));
      vecs.push_back(mk(1, 0, 9'b000_000_000, 0, e(0,0,0,0,0,0,0,0,0,0,0)));
      vecs.push_back(mk(0, 1, 9'b110_000_001, 1, e(6,0,1,0,0,0,0,0,0,0,0)));
      vecs.push_back(mk(1, 1, 9'b000_001_001, 0, e(0,1,1,1,1,0,0,0,0,0,0)));

      Reset = 1'b1;
      drive(0, 0, '0, 0);
      tick();
      tick();
      check("reset", outs(), ZEROS);
      Reset = 1'b0;
      drive(1, 0, '0, 0);
      tick();
      check("start", outs(), ZEROS);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].start, vecs[i].valid, vecs[i].in, vecs[i].zero);
         tick();
         check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end

      // Reset during the first load cycle aborts the load and returns to IDLE.
      drive(0, 1, 9'b011_101_000, 0);
      tick();
      check("ld_first", outs(), e(3,0,0,5,0,1,0,0,0,1,0));
      Reset = 1'b1;
      drive(0, 0, '0, 0);
      tick();
      check("ld_abort", outs(), ZEROS);
      Reset = 1'b0;
      drive(0, 1, 9'b000_001_001, 0);
      tick();
      check("idle_ignore", outs(), ZEROS);

      // Branch with no compare since reset is not taken, even with ZERO high.
      drive(1, 0, '0, 0);
      tick();
      check("restart", outs(), ZEROS);
      drive(0, 1, 9'b110_000_001, 1);
      tick();
      check("br_no_cmp", outs(), e(6,0,1,0,0,0,0,0,0,0,0));

      drive(0, 0, '0, 0);
      tick();
      check("bubble_end", outs(), ZEROS);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
